// File: rtl/posit_div_pkg.sv
// posit_div_pkg: FSM state type and size helpers shared by the iterative posit divider.
package posit_div_pkg;
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;
    function automatic int QB(input int n);
        return 2 * n + 1;
    endfunction
    function automatic int CYC(input int n, input int qpc);
        return (QB(n) + qpc - 1) / qpc;
    endfunction
    function automatic int TEO_W(input int rs, input int es);
        return rs + es + 5;
    endfunction
endpackage

// File: rtl/posit_div_step.sv
// posit_div_step: one radix-2 restoring division step producing a quotient bit and the next remainder.
module posit_div_step #(
    parameter int N = 32
) (
    input  logic [N:0]   rem_i,
    input  logic [N-1:0] m2_i,
    output logic [N:0]   rem_o,
    output logic         qbit_o
);
    logic [N-1:0] trial;
    // rem < 2*m2 always holds, so the difference (or an unsubtracted rem) fits in N bits
    assign qbit_o = rem_i >= {1'b0, m2_i};
    assign trial  = qbit_o ? rem_i[N-1:0] - m2_i : rem_i[N-1:0];
    assign rem_o  = {trial, 1'b0};
endmodule

// File: rtl/posit_div_seq.sv
// posit_div_seq: iterative restoring posit divider; yields normalised quotient mantissa with sticky
// plus regime/exponent scale, with valid/ready handshakes and early resolution of NaR/zero operands.
module posit_div_seq
    import posit_div_pkg::*;
#(
    parameter int N   = 32,
    parameter int ES  = 2,
    parameter int RS  = $clog2(N),
    parameter int QPC = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic                   Sign1,
    input  logic                   Sign2,
    input  logic [RS:0]            k1,
    input  logic [RS:0]            k2,
    input  logic [ES-1:0]          Exponent1,
    input  logic [ES-1:0]          Exponent2,
    input  logic [N-1:0]           Mantissa1,
    input  logic [N-1:0]           Mantissa2,
    input  logic                   inf1,
    input  logic                   inf2,
    input  logic                   zero1,
    input  logic                   zero2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*N-1:0]         Div_Mant_N,
    output logic [RS+ES+4:0]       Total_EO,
    output logic [ES-1:0]          E_O,
    output logic [RS+4:0]          R_O,
    output logic [RS+4:0]          sumR,
    output logic                   inf,
    output logic                   zero,
    output logic                   Sign
);
    localparam int QW = QB(N);
    localparam int CY = CYC(N, QPC);
    localparam int TW = TEO_W(RS, ES);
    localparam int LB = QW - (CY - 1) * QPC;
    localparam int HW = QW - LB;
    localparam int CW = $clog2(CY);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N:0]     rem_q, rem_d;
    logic [N-1:0]   m2_q, m2_d;
    logic [HW-1:0]  q_q, q_d;
    logic [RS+4:0]  kd_q, kd_d;
    logic [ES+2:0]  ed_q, ed_d;
    logic [2*N-1:0] mant_q, mant_d;
    logic [TW-1:0]  teo_q, teo_d;
    logic [ES-1:0]  eo_q, eo_d;
    logic [RS+4:0]  ro_q, ro_d, sumr_q, sumr_d;
    logic           inf_q, inf_d, zero_q, zero_d, sign_q, sign_d;
    logic           sp, last, hi, sticky;
    logic [N:0]     rem_c [QPC+1];
    logic [QPC-1:0] qc;
    logic [QW-1:0]  q_fin;
    logic [2*N-2:0] m_n;
    logic [ES+2:0]  sume;
    logic [TW-1:0]  teo, t;

    assign rem_c[0] = rem_q;
    for (genvar i = 0; i < QPC; i++) begin : g_step
        posit_div_step #(.N(N)) u_step (
            .rem_i  (rem_c[i]),
            .m2_i   (m2_q),
            .rem_o  (rem_c[i+1]),
            .qbit_o (qc[QPC-1-i])
        );
    end

    // Only the first LB bits of the final cycle belong to the quotient; the rest are discarded
    assign sp     = inf1 | inf2 | zero2;
    assign last   = cnt_q == CW'(CY - 1);
    assign q_fin  = {q_q, qc[QPC-1 -: LB]};
    assign hi     = q_fin[QW-1];
    assign m_n    = hi ? q_fin[QW-1:2] : q_fin[QW-2:1];
    assign sticky = (hi ? |q_fin[1:0] : q_fin[0]) | (|rem_c[LB]);
    assign sume   = ed_q - {{(ES+2){1'b0}}, ~hi};
    assign teo    = {kd_q, {ES{1'b0}}} + {{(RS+2){sume[ES+2]}}, sume};
    assign t      = teo[TW-1] ? -teo : teo;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        m2_d    = m2_q;
        q_d     = q_q;
        kd_d    = kd_q;
        ed_d    = ed_q;
        mant_d  = mant_q;
        teo_d   = teo_q;
        eo_d    = eo_q;
        ro_d    = ro_q;
        sumr_d  = sumr_q;
        inf_d   = inf_q;
        zero_d  = zero_q;
        sign_d  = sign_q;
        case (state_q)
            IDLE: if (in_valid && !flush) begin
                inf_d   = sp;
                zero_d  = zero1 & ~sp;
                sign_d  = Sign1 ^ Sign2;
                mant_d  = '0;
                teo_d   = '0;
                eo_d    = '0;
                ro_d    = '0;
                sumr_d  = '0;
                rem_d   = {1'b0, Mantissa1};
                m2_d    = Mantissa2;
                q_d     = '0;
                cnt_d   = '0;
                kd_d    = {{4{k1[RS]}}, k1} - {{4{k2[RS]}}, k2};
                ed_d    = {3'b000, Exponent1} - {3'b000, Exponent2};
                state_d = (sp | zero1) ? DONE : DIV;
            end
            DIV: begin
                rem_d = rem_c[QPC];
                q_d   = HW'({q_q, qc});
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    mant_d  = {m_n, sticky};
                    teo_d   = teo;
                    eo_d    = sume[ES-1:0];
                    ro_d    = t[TW-1:ES] + {{(RS+4){1'b0}}, ~teo[TW-1] | (|t[ES-1:0])};
                    sumr_d  = kd_q;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            m2_q    <= '0;
            q_q     <= '0;
            kd_q    <= '0;
            ed_q    <= '0;
            mant_q  <= '0;
            teo_q   <= '0;
            eo_q    <= '0;
            ro_q    <= '0;
            sumr_q  <= '0;
            inf_q   <= 1'b0;
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            m2_q    <= m2_d;
            q_q     <= q_d;
            kd_q    <= kd_d;
            ed_q    <= ed_d;
            mant_q  <= mant_d;
            teo_q   <= teo_d;
            eo_q    <= eo_d;
            ro_q    <= ro_d;
            sumr_q  <= sumr_d;
            inf_q   <= inf_d;
            zero_q  <= zero_d;
            sign_q  <= sign_d;
        end
    end

    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign Div_Mant_N = mant_q;
    assign Total_EO   = teo_q;
    assign E_O        = eo_q;
    assign R_O        = ro_q;
    assign sumR       = sumr_q;
    assign inf        = inf_q;
    assign zero       = zero_q;
    assign Sign       = sign_q;
endmodule

// File: tb/tb_posit_div_seq.sv
// tb_posit_div_seq: drives a QPC=1 and a QPC=4 divider in lockstep and checks both against
// an arithmetic model built on wide integer division.
module tb_posit_div_seq;
    localparam int N = 32, ES = 2, RS = 5;

    typedef struct packed {
        logic [63:0] mant;
        logic [11:0] teo;
        logic [1:0]  eo;
        logic [9:0]  ro;
        logic [9:0]  sumr;
        logic        inf, zero, sign;
    } res_t;

    typedef struct packed {
        logic        s1, s2;
        logic [5:0]  k1, k2;
        logic [1:0]  e1, e2;
        logic [31:0] m1, m2;
        logic        i1, i2, z1, z2;
    } op_t;

    logic clk = 0, reset = 1, in_valid = 0, flush = 0, out_ready = 0;
    op_t  op = '0;
    logic [1:0]  ir, ov, inf_o, zero_o, sign_o;
    logic [63:0] mant [2];
    logic [11:0] teo [2];
    logic [1:0]  eo [2];
    logic [9:0]  ro [2], sumr [2];
    res_t exp_r = '0;
    logic armed = 0;
    int   total = 0, bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        posit_div_seq #(.N(N), .ES(ES), .RS(RS), .QPC(g == 0 ? 1 : 4)) u_dut (
            .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[g]), .flush(flush),
            .Sign1(op.s1), .Sign2(op.s2), .k1(op.k1), .k2(op.k2),
            .Exponent1(op.e1), .Exponent2(op.e2), .Mantissa1(op.m1), .Mantissa2(op.m2),
            .inf1(op.i1), .inf2(op.i2), .zero1(op.z1), .zero2(op.z2),
            .out_valid(ov[g]), .out_ready(out_ready),
            .Div_Mant_N(mant[g]), .Total_EO(teo[g]), .E_O(eo[g]), .R_O(ro[g]), .sumR(sumr[g]),
            .inf(inf_o[g]), .zero(zero_o[g]), .Sign(sign_o[g])
        );
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    function automatic res_t got(input int g);
        return {mant[g], teo[g], eo[g], ro[g], sumr[g], inf_o[g], zero_o[g], sign_o[g]};
    endfunction

    function automatic res_t model(input op_t o);
        res_t r = '0;
        logic [95:0] num, q, rm;
        int se, sr, te, ta;
        r.sign = o.s1 ^ o.s2;
        r.inf  = o.i1 | o.i2 | o.z2;
        r.zero = o.z1 & ~r.inf;
        if (r.inf || r.zero) return r;
        num = {o.m1, 64'd0};
        q   = num / {64'd0, o.m2};
        rm  = num % {64'd0, o.m2};
        se  = int'(o.e1) - int'(o.e2);
        if (q[64]) r.mant = {q[64:2], (q[1:0] != 0) || (rm != 0)};
        else begin
            r.mant = {q[63:1], q[0] || (rm != 0)};
            se = se - 1;
        end
        sr = int'($signed(o.k1)) - int'($signed(o.k2));
        te = sr * 4 + se;
        ta = te < 0 ? -te : te;
        r.teo  = te[11:0];
        r.eo   = se[1:0];
        r.sumr = sr[9:0];
        r.ro   = 10'((te >= 0 || ta % 4 != 0) ? ta / 4 + 1 : ta / 4);
        return r;
    endfunction

    always @(negedge clk) if (!reset) for (int g = 0; g < 2; g++) if (ov[g]) begin
        if (armed) chk($sformatf("result_qpc%0d", g == 0 ? 1 : 4), 128'(got(g)), 128'(exp_r));
        else chk("spurious_out_valid", 128'(ov[g]), 128'(0));
    end

    // Latencies count clock edges from the accepting edge inclusive to out_valid
    task automatic run(input op_t o, input int stall, input int lat1, input int lat4);
        int n = 0, l1 = 0, l4 = 0;
        exp_r = model(o);
        armed = 1;
        op = o;
        in_valid = 1;
        out_ready = 0;
        @(posedge clk);
        #1 in_valid = 0;
        while ((l1 == 0 || l4 == 0) && n < 200) begin
            @(negedge clk);
            n++;
            if (ov[0] && l1 == 0) l1 = n;
            if (ov[1] && l4 == 0) l4 = n;
        end
        chk("latency_qpc1", 128'(l1), 128'(lat1));
        chk("latency_qpc4", 128'(l4), 128'(lat4));
        repeat (stall) begin
            @(negedge clk);
            chk("hold_in_ready", 128'(ir), 128'(0));
            chk("hold_out_valid", 128'(ov), 128'(2'b11));
        end
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        chk("in_ready_back", 128'(ir), 128'(2'b11));
        chk("out_valid_drop", 128'(ov), 128'(0));
        armed = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        op_t v1, v2, v3, v4, v5, v6, v7, v8;
        res_t m;
        v1 = '{1'b0, 1'b0, 6'd0, 6'd0, 2'd0, 2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        v2 = '{1'b0, 1'b0, 6'd0, 6'd0, 2'd0, 2'd0, 32'h8000_0000, 32'hC000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        v3 = '{1'b1, 1'b0, 6'd4, 6'd1, 2'd2, 2'd1, 32'h9000_0000, 32'hA000_0000, 1'b0, 1'b0, 1'b0, 1'b1};
        v4 = '{1'b1, 1'b1, 6'd2, 6'd1, 2'd1, 2'd0, 32'h9000_0000, 32'hA000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
        v5 = '{1'b0, 1'b1, 6'd0, 6'd0, 2'd0, 2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        v6 = '{1'b0, 1'b1, 6'd3, 6'h3E, 2'd1, 2'd3, 32'hC000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        v7 = '{1'b0, 1'b0, 6'h3D, 6'd0, 2'd0, 2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        v8 = '{1'b0, 1'b0, 6'h3F, 6'd0, 2'd0, 2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("reset_out_qpc1", 128'(got(0)), 128'(0));
        chk("reset_out_qpc4", 128'(got(1)), 128'(0));
        chk("reset_in_ready", 128'(ir), 128'(2'b11));
        chk("reset_out_valid", 128'(ov), 128'(0));

        m = model(v1);
        chk("pin_v1_mant", 128'(m.mant), 128'(64'h8000_0000_0000_0000));
        chk("pin_v1_teo", 128'(m.teo), 128'(0));
        chk("pin_v1_ro", 128'(m.ro), 128'(1));
        m = model(v2);
        chk("pin_v2_mant", 128'(m.mant), 128'(64'hAAAA_AAAA_AAAA_AAAB));
        chk("pin_v2_eo", 128'(m.eo), 128'(3));
        chk("pin_v2_teo", 128'(m.teo), 128'(12'hFFF));
        chk("pin_v2_ro", 128'(m.ro), 128'(1));
        m = model(v3);
        chk("pin_v3", 128'(m), 128'({64'd0, 12'd0, 2'd0, 10'd0, 10'd0, 3'b101}));
        m = model(v4);
        chk("pin_v4", 128'(m), 128'({64'd0, 12'd0, 2'd0, 10'd0, 10'd0, 3'b010}));
        m = model(v6);
        chk("pin_v6", 128'(m), 128'({64'hC000_0000_0000_0000, 12'd18, 2'd2, 10'd5, 10'd5, 3'b001}));
        m = model(v7);
        chk("pin_v7", 128'(m), 128'({64'h8000_0000_0000_0000, 12'hFF4, 2'd0, 10'd3, 10'h3FD, 3'b000}));
        m = model(v8);
        chk("pin_v8", 128'(m), 128'({64'h8000_0000_0000_0000, 12'hFFB, 2'd3, 10'd2, 10'h3FF, 3'b000}));

        run(v1, 0, 66, 18);
        run(v2, 10, 66, 18);
        run(v3, 0, 1, 1);
        run(v4, 0, 1, 1);
        run(v5, 0, 1, 1);
        run(v6, 0, 66, 18);
        run(v7, 0, 66, 18);
        run(v8, 0, 66, 18);

        op = v2;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        repeat (11) @(posedge clk);
        #1 flush = 1;
        @(posedge clk);
        #1 flush = 0;
        chk("flush_div_in_ready", 128'(ir), 128'(2'b11));
        repeat (80) @(negedge clk);
        chk("flush_div_quiet", 128'(ov), 128'(0));

        op = v6;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        repeat (12) @(negedge clk);
        #2 reset = 1;
        #1 chk("reset_mid_async", 128'(ov), 128'(0));
        @(negedge clk);
        chk("reset_mid_out_qpc1", 128'(got(0)), 128'(0));
        chk("reset_mid_out_qpc4", 128'(got(1)), 128'(0));
        reset = 0;
        repeat (80) @(negedge clk);
        chk("reset_mid_quiet", 128'(ov), 128'(0));
        chk("reset_mid_in_ready", 128'(ir), 128'(2'b11));

        op = v1;
        in_valid = 1;
        flush = 1;
        @(posedge clk);
        #1 in_valid = 0;
        flush = 0;
        chk("flush_accept_in_ready", 128'(ir), 128'(2'b11));
        repeat (70) @(negedge clk);
        chk("flush_accept_quiet", 128'(ov), 128'(0));

        exp_r = model(v3);
        armed = 1;
        op = v3;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        chk("flush_done_valid", 128'(ov), 128'(2'b11));
        flush = 1;
        @(posedge clk);
        #1 flush = 0;
        armed = 0;
        @(negedge clk);
        chk("flush_done_drop", 128'(ov), 128'(0));
        chk("flush_done_in_ready", 128'(ir), 128'(2'b11));

        run(v2, 0, 66, 18);

        for (int i = 0; i < 150; i++) begin
            op_t o;
            logic [31:0] a, b;
            bit sp;
            a = $urandom();
            b = $urandom();
            o = '{a[0], a[1], a[7:2], a[13:8], a[15:14], a[17:16],
                  32'($urandom()) | 32'h8000_0000, 32'($urandom()) | 32'h8000_0000,
                  b[3:0] == 0, b[7:4] == 0, b[11:8] == 0, b[15:12] == 0};
            sp = o.i1 | o.i2 | o.z1 | o.z2;
            run(o, i % 3, sp ? 1 : 66, sp ? 1 : 18);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
